// File: rtl/sort_xform_pkg.sv
// sort_xform_pkg: shared state encoding, option bit positions and element sizing for the sort/transform engine.
package sort_xform_pkg;
    typedef enum logic [2:0] {IDLE, SORT, XFORM, CALC, OUT} state_e;
    localparam int OPT_SIGNED   = 0;
    localparam int OPT_DESC     = 1;
    localparam int OPT_AVG      = 2;
    localparam int EQU_WEIGHTED = 0;
    // Two guard bits keep offset differences and sign extension inside one signed element.
    function automatic int elem_w(input int w);
        return w + 2;
    endfunction
endpackage

// File: rtl/cmp_swap_cell.sv
// cmp_swap_cell: one compare-exchange stage of the odd-even transposition network.
module cmp_swap_cell #(
    parameter int E = 6
) (
    input  logic signed [E-1:0] a_i,
    input  logic signed [E-1:0] b_i,
    input  logic                desc_i,
    input  logic                en_i,
    output logic signed [E-1:0] lo_o,
    output logic signed [E-1:0] hi_o
);
    logic swap;
    assign swap = en_i && (desc_i ? a_i < b_i : a_i > b_i);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/sort_xform_engine.sv
// sort_xform_engine: iterative sort, offset/average transform and closing equation over N operands.
module sort_xform_engine
    import sort_xform_pkg::*;
#(
    parameter int N  = 6,
    parameter int W  = 4,
    parameter int OW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [2:0]      opt,
    input  logic [1:0]      equ,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_n
);
    localparam int E  = elem_w(W);
    localparam int CW = 2 * E + 4;
    localparam logic signed [CW-1:0] THREE = CW'(3);
    localparam logic [4:0] LAST = 5'(N - 1);

    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] opt_q, opt_d;
    logic [1:0] equ_q, equ_d;
    logic [OW-1:0] out_q, out_d;
    logic signed [E-1:0] a_q [N];
    logic signed [E-1:0] a_d [N];
    logic signed [E-1:0] lo_w [N-1];
    logic signed [E-1:0] hi_w [N-1];
    logic signed [CW-1:0] am3, am2, am1, a1, a0, weighted_w, diff_w, r_w, avg;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign out_n     = out_q;

    for (genvar j = 0; j < N - 1; j++) begin : g_cell
        cmp_swap_cell #(.E(E)) u_cell (
            .a_i    (a_q[j]),
            .b_i    (a_q[j+1]),
            .desc_i (opt_q[OPT_DESC]),
            .en_i   (cnt_q[0] == 1'(j % 2)),
            .lo_o   (lo_w[j]),
            .hi_o   (hi_w[j])
        );
    end

    assign am3        = CW'(a_q[N-3]);
    assign am2        = CW'(a_q[N-2]);
    assign am1        = CW'(a_q[N-1]);
    assign a1         = CW'(a_q[1]);
    assign a0         = CW'(a_q[0]);
    assign weighted_w = ((am3 + (am2 <<< 2)) * am1) / THREE;
    assign diff_w     = am1 * a1 - am1 * a0;
    assign r_w        = equ_q == 2'(EQU_WEIGHTED) ? weighted_w : (diff_w[CW-1] ? -diff_w : diff_w);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opt_d   = opt_q;
        equ_d   = equ_q;
        out_d   = out_q;
        a_d     = a_q;
        avg     = '0;
        case (state_q)
            IDLE: if (in_valid) begin
                opt_d = opt;
                equ_d = equ;
                for (int i = 0; i < N; i++)
                    a_d[i] = opt[OPT_SIGNED] ? {{(E-W){in_data[i*W+W-1]}}, in_data[i*W +: W]}
                                             : {{(E-W){1'b0}}, in_data[i*W +: W]};
                cnt_d   = '0;
                state_d = SORT;
            end
            SORT: begin
                for (int j = 0; j < N - 1; j++)
                    if (cnt_q[0] == 1'(j % 2)) begin
                        a_d[j]   = lo_w[j];
                        a_d[j+1] = hi_w[j];
                    end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    cnt_d   = 5'd1;
                    state_d = XFORM;
                end
            end
            XFORM: if (opt_q[OPT_AVG]) begin
                // One element per cycle so each step sees its already-averaged predecessor.
                for (int i = 1; i < N; i++)
                    if (cnt_q == 5'(i)) begin
                        avg    = (CW'(a_q[i-1]) + CW'(a_q[i-1]) + CW'(a_q[i])) / THREE;
                        a_d[i] = avg[E-1:0];
                    end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = CALC;
            end else begin
                for (int i = 0; i < N; i++) a_d[i] = a_q[i] - a_q[0];
                state_d = CALC;
            end
            CALC: begin
                out_d   = r_w[OW-1:0];
                state_d = OUT;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opt_q   <= '0;
            equ_q   <= '0;
            out_q   <= '0;
            for (int i = 0; i < N; i++) a_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opt_q   <= opt_d;
            equ_q   <= equ_d;
            out_q   <= out_d;
            for (int i = 0; i < N; i++) a_q[i] <= a_d[i];
        end
    end
endmodule

// File: tb/tb_sort_xform_engine.sv
// tb_sort_xform_engine: vector table with a result scoreboard, plus backpressure and mid-sort reset sequences.
module tb_sort_xform_engine;
    localparam int N  = 6;
    localparam int W  = 4;
    localparam int OW = 10;

    typedef struct {
        logic [N*W-1:0] data;
        logic [2:0]     opt;
        logic [1:0]     equ;
        int             exp;
        int             lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [2:0] opt = '0;
    logic [1:0] equ = '0;
    logic in_ready, out_valid;
    logic [OW-1:0] out_n;

    vec_t v [14];
    logic [OW-1:0] exp_q [$];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sort_xform_engine #(.N(N), .W(W), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .opt       (opt),
        .equ       (equ),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [N*W-1:0] d, input logic [2:0] o, input logic [1:0] e, input logic [OW-1:0] x);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready before send", int'(in_ready), 1);
        in_data  = d;
        opt      = o;
        equ      = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '1;
        opt      = ~o;
        equ      = ~e;
        exp_q.push_back(x);
    endtask

    task automatic get(input string name, input int lat);
        int n = 0;
        logic [OW-1:0] x;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, n, lat);
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: result with empty scoreboard, got %0d", name, out_n);
        end else begin
            x = exp_q.pop_front();
            check({name, " out_n"}, int'(out_n), int'(x));
        end
    endtask

    initial begin
        int seen;
        v[0]  = '{24'h951413, 3'd0, 2'd0, 50, 8};
        v[1]  = '{24'h951413, 3'd0, 2'd1, 0, 8};
        v[2]  = '{24'h951413, 3'd1, 2'd1, 96, 8};
        v[3]  = '{24'h951413, 3'd1, 2'd0, 216, 8};
        v[4]  = '{24'h951413, 3'd4, 2'd0, 23, 12};
        v[5]  = '{24'h951413, 3'd2, 2'd1, 32, 8};
        v[6]  = '{24'h951413, 3'd2, 2'd0, 101, 8};
        v[7]  = '{24'h951413, 3'd3, 2'd2, 12, 8};
        v[8]  = '{24'h951413, 3'd6, 2'd0, 11, 12};
        v[9]  = '{24'h951413, 3'd5, 2'd0, 2, 12};
        v[10] = '{24'h951413, 3'd5, 2'd3, 6, 12};
        v[11] = '{24'h951413, 3'd7, 2'd0, 1022, 12};
        v[12] = '{24'h628F07, 3'd0, 2'd0, 195, 8};
        v[13] = '{24'h628F07, 3'd1, 2'd0, 330, 8};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_n", int'(out_n), 0);

        for (int i = 0; i < 14; i++) begin
            send(v[i].data, v[i].opt, v[i].equ, OW'(v[i].exp));
            get($sformatf("vec%0d", i), v[i].lat);
            @(posedge clk); #1;
            check($sformatf("vec%0d pulse out_valid", i), int'(out_valid), 0);
            check($sformatf("vec%0d pulse in_ready", i), int'(in_ready), 1);
        end

        out_ready = 1'b0;
        send(24'h951413, 3'd0, 2'd0, 10'd50);
        in_valid = 1'b1;
        in_data  = 24'h777777;
        opt      = 3'd7;
        equ      = 2'd0;
        repeat (3) begin
            @(posedge clk); #1;
            check("busy in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        get("bp", 5);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold out_valid", int'(out_valid), 1);
            check("hold out_n", int'(out_n), 50);
            check("hold in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release out_valid", int'(out_valid), 0);
        check("release in_ready", int'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no phantom result", seen, 0);

        send(24'h951413, 3'd0, 2'd0, 10'd50);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort out_valid", int'(out_valid), 0);
        check("abort in_ready", int'(in_ready), 1);
        check("abort out_n", int'(out_n), 0);
        exp_q.delete();
        send(24'h951413, 3'd4, 2'd0, 10'd23);
        get("post-reset", 12);
        send(24'h628F07, 3'd1, 2'd0, 10'd330);
        get("post-reset b2b", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sort_xform_engine.md
Name: sort_xform_engine

Overview:
- Sequential, parametrised successor to the Lab01 six-number sort-and-compute datapath.
- Accepts N W-bit operands plus mode bits over a valid/ready handshake.
- Sorts them iteratively with odd-even transposition, then applies an offset or cumulative-average transform, then evaluates a selectable closing equation.
- Returns one OW-bit result through an output handshake with backpressure.

Parameters:
- N, 6, number of operands (legal 4..16)
- W, 4, operand width in bits
- OW, 10, result width in bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- in_data  in  N*W  operand i at bits [i*W +: W]
- opt  in  3  [0] signed, [1] descending, [2] average mode (0 = offset mode)
- equ  in  2  0 = weighted equation, any other value = difference magnitude
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_n  out  OW  result

Behaviour:
- Reset:
  - rst sampled high at a clk edge forces state IDLE, in_ready=1, out_valid=0, out_n=0.
  - All element registers clear.
  - A bundle in flight is discarded, including reset asserted mid-SORT or mid-OUT.
- Accept: happens at an edge where in_valid && in_ready. That edge latches operands, opt and equ. Later changes on the inputs have no effect.
- in_ready is high only in IDLE. in_valid in any other state is ignored.
- Element width: internal elements are E = W+2 bits signed.
  - Load: opt[0]=1 sign-extends, opt[0]=0 zero-extends.
- States:
  - IDLE
  - SORT: exactly N cycles. Pass k compares pairs (j, j+1) with j ≡ k mod 2, all pairs in parallel. A pair swaps when out of order: a[j] > a[j+1] for ascending, a[j] < a[j+1] for descending, signed compare. Equal elements never swap.
  - XFORM:
    - Offset mode: 1 cycle. a[i] = a[i] - a[0] for every i, so a[0] = 0.
    - Average mode: N-1 cycles. Cycle i (1..N-1) computes a[i] = (2*a[i-1] + a[i]) / 3, using the already-updated a[i-1]. a[0] is unchanged.
  - CALC: 1 cycle. Signed arithmetic at 2E+4 bits, division truncates toward zero.
    - equ==0: r = ((a[N-3] + 4*a[N-2]) * a[N-1]) / 3
    - else: r = |a[N-1]*a[1] - a[N-1]*a[0]|
    - out_n = r[OW-1:0] (two's complement truncation).
  - OUT: out_valid=1 and out_n is held stable until out_ready. At the edge with out_valid && out_ready the block goes to IDLE, out_valid=0, and in_ready=1 from that edge.
- Latency: out_valid rises at edge N+X+1 after the accept edge, where X=1 in offset mode and X=N-1 in average mode. For N=6 that is 8 or 12 edges.
- Throughput: no accept is possible in the cycle out_valid drops.
- Back-to-back: a new accept is legal from the first IDLE cycle.
- out_ready held high permanently: out_valid is a one-cycle pulse.

Decomposition:
- Package sort_xform_pkg holds:
  - state enum (IDLE, SORT, XFORM, CALC, OUT)
  - opt bit-index constants OPT_SIGNED=0, OPT_DESC=1, OPT_AVG=2
  - EQU_WEIGHTED=0
  - element-width function E(W)
- Sub-module cmp_swap_cell (one per pair, generated): two E-bit inputs, desc bit, enable → ordered outputs.

Test Plan:
- N=6, W=4, in_data {3,1,4,1,5,9}, opt=000, equ=0 → sorted 1,1,3,4,5,9, offset 0,0,2,3,4,8 → out_n=50 at edge 8. Same bundle with equ=1 → out_n=0.
- Same operands, opt=001 (9 reads as -7) → offset 0,8,8,10,11,12. equ=1 → out_n=96. equ=0 → out_n=216.
- Same operands, opt=100, equ=0 → average 1,1,1,2,3,5 → out_n=23 at edge 12.
- Same operands, opt=010, equ=1 → offset 0,-4,-5,-6,-8,-8 → out_n=32. equ=0 → out_n=101.
- Backpressure and busy:
  - Hold out_ready=0 for 5 cycles: out_valid and out_n must stay stable.
  - Pulse in_valid while busy: nothing is accepted, in_ready stays 0.
  - Release out_ready: IDLE on the next edge.
- Reset mid-SORT (cycle 3): next cycle out_valid=0, in_ready=1. A following bundle produces the correct result with no residue from the aborted one.
